// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the hardwired ALU control sequencer:
//   - sequencer state encoding
//   - instruction opcodes and the ALU operation codes they map to
//   - instruction field bit positions
//   - fault codes
//   - helpers that classify an opcode and translate it to an ALU code
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    // Instruction opcodes (IR[31:27])
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] HALT_OP = 5'b11011;

    // ALU operation codes driven on ALU_select
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00100;
    localparam logic [4:0] ALU_OR  = 5'b00101;
    localparam logic [4:0] ALU_SHR = 5'b00110;
    localparam logic [4:0] ALU_SHL = 5'b00111;

    // Instruction field positions
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // Fault codes
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // True for the three-operand register ALU instructions
    function automatic logic is_alu_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Opcode to ALU operation code; non-ALU opcodes fall back to ADD,
    // which is harmless because ALU_select is only driven in T4.
    function automatic logic [4:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_sequencer_reg_sel_decode.sv
// ---------------------------------------------------------------------------
// reg_sel_decode
// 4-to-16 one-hot register select decoder with enable. Used once for the
// register load enables (Rin) and once for the register drive enables (Rout).
//   i_en      : enable; when low the output is all zeros
//   i_sel     : register number 0..15
//   o_onehot  : one-hot select, bit i_sel set when enabled
// ---------------------------------------------------------------------------
module reg_sel_decode (
    input  logic        i_en,
    input  logic [3:0]  i_sel,
    output logic [15:0] o_onehot
);

    always_comb begin
        o_onehot = 16'h0000;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// alu_ctrl_sequencer
// Hardwired control unit for the single-bus datapath. Sequences instruction
// fetch (T0-T2, with a memory-ready wait and timeout in T1) and three-operand
// register ALU execution (T3-T5), generating every datapath strobe.
//
// Ports:
//   Clock       : system clock, rising edge
//   clr         : asynchronous active-low reset
//   run         : start/continue; sampled in IDLE and at the end of T5
//   stop        : request halt once the current instruction completes
//   mem_ready   : memory data valid; MDR captures in that T1 cycle
//   IR          : instruction register contents from the datapath
//   Rin/Rout    : one-hot register load / drive enables R0..R15
//   PCout, Zlowout, MDRout              : bus drive enables
//   PCin, IRin, Yin, Zin, MARin, MDRin  : register load enables
//   IncPC, Read : PC increment select; memory read / MDR source select
//   ALU_select  : ALU operation code (valid in T4)
//   halted      : sequencer is in HALT
//   fault       : 00 none, 01 illegal opcode, 10 memory timeout
//   instr_count : retired instruction count (wraps)
//   dbg_state   : current sequencer state, for observation only
//
// Handshake: mem_ready is a single-sided valid. The sequencer holds Read and
// MDRin high for as long as it sits in T1; the first cycle mem_ready is seen
// high is the cycle the MDR captures, and T2 follows.
// ---------------------------------------------------------------------------
module alu_ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             Clock,
    input  logic             clr,
    input  logic             run,
    input  logic             stop,
    input  logic             mem_ready,
    input  logic [31:0]      IR,
    output logic [15:0]      Rin,
    output logic [15:0]      Rout,
    output logic             PCout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             PCin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             MARin,
    output logic             MDRin,
    output logic             IncPC,
    output logic             Read,
    output logic [4:0]       ALU_select,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       dbg_state
);

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic [1:0]        r_fault;
    logic [CNT_W-1:0]  r_instr_count;
    logic              r_stop_req;

    logic [4:0]        w_op;
    logic [3:0]        w_ra;
    logic [3:0]        w_rb;
    logic [3:0]        w_rc;
    logic              w_is_alu;
    logic              w_timeout;
    logic              w_end_instr;
    logic              w_rin_en;
    logic              w_rout_en;
    logic [3:0]        w_rout_sel;
    logic              w_unused_ir;

    // Instruction field extraction
    assign w_op        = IR[OP_MSB:OP_LSB];
    assign w_ra        = IR[RA_MSB:RA_LSB];
    assign w_rb        = IR[RB_MSB:RB_LSB];
    assign w_rc        = IR[RC_MSB:RC_LSB];
    assign w_is_alu    = is_alu_op(w_op);
    assign w_unused_ir = ^IR[RC_LSB-1:0];

    // Final T1 cycle without data: the fetch is abandoned
    assign w_timeout   = (r_state == S_T1) && !mem_ready && (r_to_cnt == TO_LAST);

    // A stop pulse seen at any point of the instruction is remembered until
    // the T5 decision so a short pulse still ends the run cleanly.
    assign w_end_instr = stop || r_stop_req || !run;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (run) w_next_state = S_T0;
            S_T0:   w_next_state = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    w_next_state = S_T2;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                end
            end
            S_T2:   w_next_state = S_T3;
            S_T3:   w_next_state = w_is_alu ? S_T4 : S_HALT;
            S_T4:   w_next_state = S_T5;
            S_T5:   w_next_state = w_end_instr ? S_IDLE : S_T0;
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output (strobe) logic: Moore, from state and IR only
    // ------------------------------------------------------------------
    always_comb begin
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        MDRout     = 1'b0;
        PCin       = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        ALU_select = 5'b00000;
        w_rin_en   = 1'b0;
        w_rout_en  = 1'b0;
        w_rout_sel = w_rb;
        case (r_state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                // Z still holds PC+1, so reloading PC each wait cycle is idempotent
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                // HALT and undefined opcodes leave T3 with no strobes
                if (w_is_alu) begin
                    w_rout_en  = 1'b1;
                    w_rout_sel = w_rb;
                    Yin        = 1'b1;
                end
            end
            S_T4: begin
                w_rout_en  = 1'b1;
                w_rout_sel = w_rc;
                Zin        = 1'b1;
                ALU_select = alu_code(w_op);
            end
            S_T5: begin
                Zlowout  = 1'b1;
                w_rin_en = 1'b1;
            end
            default: ;
        endcase
    end

    reg_sel_decode u_rin_dec (
        .i_en     (w_rin_en),
        .i_sel    (w_ra),
        .o_onehot (Rin)
    );

    reg_sel_decode u_rout_dec (
        .i_en     (w_rout_en),
        .i_sel    (w_rout_sel),
        .o_onehot (Rout)
    );

    // ------------------------------------------------------------------
    // Memory wait counter: cleared on each fetch, advanced per idle T1 cycle
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            r_to_cnt <= '0;
        end else if (r_state == S_T0) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_T1) && !mem_ready && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Fault code: set on entry to HALT, held until clr
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            r_fault <= FAULT_NONE;
        end else if (w_timeout) begin
            r_fault <= FAULT_TIMEOUT;
        end else if ((r_state == S_T3) && !w_is_alu && (w_op != HALT_OP)) begin
            r_fault <= FAULT_ILLEGAL;
        end
    end

    // ------------------------------------------------------------------
    // Retired instruction counter and latched stop request
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            r_instr_count <= '0;
        end else if (r_state == S_T5) begin
            r_instr_count <= r_instr_count + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            r_stop_req <= 1'b0;
        end else if ((r_state == S_T5) || (r_state == S_IDLE) || (r_state == S_HALT)) begin
            r_stop_req <= 1'b0;
        end else if (stop) begin
            r_stop_req <= 1'b1;
        end
    end

    assign halted      = (r_state == S_HALT);
    assign fault       = r_fault;
    assign instr_count = r_instr_count;
    assign dbg_state   = r_state;

endmodule
